// File: rtl/spi_flash_read_sequencer.sv
// spi_flash_read_sequencer
//   Accepts host read requests, issues one access to the SPI master
//   controller, captures the returned bytes into a FIFO and streams them
//   back to the host with a last marker.
//
// Optional feature macro: SPI_FAST_READ_EN
//   When defined, adds input req_fast selecting fast read (0x0B, 8 dummy clocks).
//
// Ports:
//   clk, reset_n                         clock, async active-low reset
//   req_valid/req_ready/req_addr/req_len host request channel (len = bytes-1)
//   access_request ... data_valid        controller access-request field bundle
//   access_complete                      controller transaction-done pulse
//   write_enable/write_data              controller received-byte strobe
//   rd_valid/rd_ready/rd_data/rd_last    host byte stream
//   busy                                 sequencer not idle
//   xfer_error                           pulse on completion with bad byte count/overflow
module spi_flash_read_sequencer #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_BYTES = 3,
    parameter logic [7:0]  READ_CMD   = 8'h03
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [7:0]  req_len,
`ifdef SPI_FAST_READ_EN
    input  logic        req_fast,
`endif
    output logic        access_request,
    output logic        read_write_n,
    output logic [7:0]  command,
    output logic [31:0] address,
    output logic [1:0]  address_bytes,
    output logic        address_valid,
    output logic [2:0]  dummy_cycles,
    output logic        dummy_valid,
    output logic [7:0]  data_bytes,
    output logic        data_valid,
    input  logic        access_complete,
    input  logic        write_enable,
    input  logic [7:0]  write_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [7:0]  rd_data,
    output logic        rd_last,
    output logic        busy,
    output logic        xfer_error
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t         state, state_nxt;
    logic [31:0]    addr_q;
    logic [7:0]     len_q;
`ifdef SPI_FAST_READ_EN
    logic           fast_q;
`endif
    logic [8:0]     rx_cnt, rx_cnt_nxt;
    logic           overflow;

    logic [8:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;

    logic accept, strobe, push_ok, pop, full, empty, last_bit;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign pop      = !empty && rd_ready;
    // In-range strobes always advance rx_cnt; a full FIFO only loses the byte.
    assign strobe   = (state == WAIT) && write_enable && (rx_cnt <= {1'b0, len_q});
    assign push_ok  = strobe && (!full || pop);
    assign last_bit = (rx_cnt == {1'b0, len_q});
    assign rx_cnt_nxt = rx_cnt + {8'd0, strobe};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        accept         = 1'b0;
        access_request = 1'b0;
        xfer_error     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && empty) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                access_request = 1'b1;
                state_nxt      = WAIT;
            end
            WAIT: begin
                if (access_complete) begin
                    state_nxt  = IDLE;
                    // Count and overflow include any strobe landing in this cycle.
                    xfer_error = (rx_cnt_nxt != ({1'b0, len_q} + 9'd1)) ||
                                 overflow || (strobe && !push_ok);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q   <= '0;
            len_q    <= '0;
`ifdef SPI_FAST_READ_EN
            fast_q   <= 1'b0;
`endif
            rx_cnt   <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            addr_q   <= req_addr;
            len_q    <= req_len;
`ifdef SPI_FAST_READ_EN
            fast_q   <= req_fast;
`endif
            rx_cnt   <= '0;
            overflow <= 1'b0;
        end else begin
            rx_cnt <= rx_cnt_nxt;
            if (strobe && !push_ok) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {last_bit, write_data};
    end

    assign req_ready     = (state == IDLE) && empty;
    assign busy          = (state != IDLE);
    assign rd_valid      = !empty;
    assign rd_data       = mem[rd_ptr][7:0];
    assign rd_last       = !empty && mem[rd_ptr][8];

    assign read_write_n  = 1'b1;
    assign address       = addr_q;
    assign address_bytes = 2'(ADDR_BYTES - 1);
    assign address_valid = 1'b1;
    assign data_bytes    = len_q;
    assign data_valid    = 1'b1;
`ifdef SPI_FAST_READ_EN
    assign command       = fast_q ? 8'h0B : READ_CMD;
    assign dummy_valid   = fast_q;
    assign dummy_cycles  = fast_q ? 3'd7 : 3'd0;
`else
    assign command       = READ_CMD;
    assign dummy_valid   = 1'b0;
    assign dummy_cycles  = 3'd0;
`endif

endmodule

// File: tb/tb_spi_flash_read_sequencer.sv
module tb_spi_flash_read_sequencer;

    logic        clk, reset_n;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
`ifdef SPI_FAST_READ_EN
    logic        req_fast;
`endif
    logic        access_request, read_write_n;
    logic [7:0]  command;
    logic [31:0] address;
    logic [1:0]  address_bytes;
    logic        address_valid;
    logic [2:0]  dummy_cycles;
    logic        dummy_valid;
    logic [7:0]  data_bytes;
    logic        data_valid;
    logic        access_complete, write_enable;
    logic [7:0]  write_data;
    logic        rd_valid, rd_ready;
    logic [7:0]  rd_data;
    logic        rd_last, busy, xfer_error;

    spi_flash_read_sequencer #(.FIFO_DEPTH(16), .ADDR_BYTES(3), .READ_CMD(8'h03)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
`ifdef SPI_FAST_READ_EN
        .req_fast(req_fast),
`endif
        .access_request(access_request), .read_write_n(read_write_n), .command(command),
        .address(address), .address_bytes(address_bytes), .address_valid(address_valid),
        .dummy_cycles(dummy_cycles), .dummy_valid(dummy_valid), .data_bytes(data_bytes),
        .data_valid(data_valid), .access_complete(access_complete),
        .write_enable(write_enable), .write_data(write_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .busy(busy), .xfer_error(xfer_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  tx[$];
    logic [8:0]  got[$];
    logic [8:0]  exp_q[$];
    bit          exp_err;
    int          err_pulses, ar_pulses;
    logic [31:0] cap_addr;
    logic [7:0]  cap_len, cap_cmd;
    logic [1:0]  cap_ab;
    logic [2:0]  cap_dc;
    logic        cap_dv;

    // One cycle: sample just after the falling edge, then advance to the next one.
    task automatic tick();
        #1;
        if (rd_valid && rd_ready) got.push_back({rd_last, rd_data});
        if (xfer_error) err_pulses++;
        if (access_request) begin
            ar_pulses++;
            cap_addr = address; cap_len = data_bytes; cap_cmd = command;
            cap_ab = address_bytes; cap_dc = dummy_cycles; cap_dv = dummy_valid;
        end
        @(negedge clk);
    endtask

    // Host request plus controller model returning tx[0..n-1], then access_complete.
    task automatic run_xfer(input logic [31:0] a, input logic [7:0] len, input int n, input bit rnd);
        bit done;
        got.delete(); err_pulses = 0; ar_pulses = 0; done = 0;
        req_valid = 1'b1; req_addr = a; req_len = len;
        tick();
        req_valid = 1'b0; req_addr = $urandom; req_len = 8'($urandom);
        tick();
        for (int i = 0; i < n; i++) begin
            if (rnd && ($urandom % 3 == 0)) begin
                write_enable = 1'b0; rd_ready = 1'($urandom);
                tick();
            end
            write_enable = 1'b1; write_data = tx[i];
            rd_ready = rnd ? 1'($urandom) : 1'b0;
            if (rnd && i == n - 1 && ($urandom % 2 == 1)) begin
                access_complete = 1'b1; done = 1;
            end
            tick();
        end
        write_enable = 1'b0;
        if (!done) begin
            access_complete = 1'b1;
            tick();
        end
        access_complete = 1'b0; rd_ready = 1'b0;
    endtask

    task automatic drain();
        rd_ready = 1'b1;
        repeat (40) tick();
        rd_ready = 1'b0;
    endtask

    // Reference: only the first len+1 strobes are data; without popping only 16 fit.
    task automatic model(input int len, input int n, input bit rnd);
        int k, s;
        k = (n < len + 1) ? n : len + 1;
        s = (!rnd && k > 16) ? 16 : k;
        exp_q.delete();
        for (int i = 0; i < s; i++) exp_q.push_back({(i == len), tx[i]});
        exp_err = (k != len + 1) || (!rnd && k > 16);
    endtask

    task automatic fill_tx(input int n);
        tx.delete();
        for (int i = 0; i < n; i++) tx.push_back(8'($urandom));
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        checks++; if ({access_request, rd_valid, rd_last, xfer_error, busy} !== 5'b0) begin
            errors++; $display("FAIL reset_ctl got %b expected 00000", {access_request, rd_valid, rd_last, xfer_error, busy}); end
        checks++; if ({command, address, data_bytes} !== {8'h03, 32'h0, 8'h0}) begin
            errors++; $display("FAIL reset_fields got %h/%h/%h expected 03/0/0", command, address, data_bytes); end
        checks++; if ({dummy_valid, dummy_cycles, req_ready} !== 5'b00001) begin
            errors++; $display("FAIL reset_dummy_ready got %b expected 00001", {dummy_valid, dummy_cycles, req_ready}); end
        checks++; if ({read_write_n, address_valid, data_valid, address_bytes} !== 5'b11110) begin
            errors++; $display("FAIL const_fields got %b expected 11110", {read_write_n, address_valid, data_valid, address_bytes}); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        tx = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        run_xfer(32'h00012345, 8'd3, 4, 0);
        model(3, 4, 0);
        checks++; if (ar_pulses !== 1) begin errors++; $display("FAIL single_ar got %0d expected 1", ar_pulses); end
        checks++; if ({cap_addr, cap_len, cap_ab} !== {32'h00012345, 8'd3, 2'd2}) begin
            errors++; $display("FAIL single_fields got %h/%h/%h expected 00012345/03/2", cap_addr, cap_len, cap_ab); end
        checks++; if ({cap_cmd, cap_dv, cap_dc} !== {8'h03, 1'b0, 3'd0}) begin
            errors++; $display("FAIL single_cmd got %h/%b/%0d expected 03/0/0", cap_cmd, cap_dv, cap_dc); end
        checks++; if ({rd_valid, req_ready, busy} !== 3'b100) begin
            errors++; $display("FAIL single_pre_drain got %b expected 100", {rd_valid, req_ready, busy}); end
        drain();
        checks++; if (got.size() !== exp_q.size()) begin errors++; $display("FAIL single_count got %0d expected %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL single_byte%0d got %h expected %h", i, got[i], exp_q[i]); end
        end
        checks++; if (err_pulses !== 0) begin errors++; $display("FAIL single_err got %0d expected 0", err_pulses); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b expected 1", req_ready); end
    endtask

    task automatic test_backpressure();
        logic [8:0] held;
        fill_tx(20);
        run_xfer(32'hCAFE0000, 8'd19, 20, 0);
        model(19, 20, 0);
        checks++; if (err_pulses !== 1) begin errors++; $display("FAIL bp_err got %0d expected 1", err_pulses); end
        held = {rd_last, rd_data};
        repeat (3) tick();
        checks++; if ({rd_valid, rd_last, rd_data} !== {1'b1, held}) begin
            errors++; $display("FAIL bp_hold got %h expected %h", {rd_valid, rd_last, rd_data}, {1'b1, held}); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %b expected 0", req_ready); end
        drain();
        checks++; if (got.size() !== exp_q.size()) begin errors++; $display("FAIL bp_count got %0d expected %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL bp_byte%0d got %h expected %h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_len_mismatch(input int len, input int n);
        fill_tx(n);
        run_xfer($urandom, 8'(len), n, 0);
        drain();
        model(len, n, 0);
        checks++; if (err_pulses !== int'(exp_err)) begin
            errors++; $display("FAIL mis%0d_%0d_err got %0d expected %0d", len, n, err_pulses, exp_err); end
        checks++; if (got.size() !== exp_q.size()) begin
            errors++; $display("FAIL mis%0d_%0d_count got %0d expected %0d", len, n, got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL mis%0d_%0d_byte%0d got %h expected %h", len, n, i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        fill_tx(8);
        got.delete();
        req_valid = 1'b1; req_addr = 32'h1000; req_len = 8'd7;
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            write_enable = 1'b1; write_data = tx[i];
            tick();
        end
        write_enable = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({rd_valid, rd_last, busy, access_request, xfer_error} !== 5'b0) begin
            errors++; $display("FAIL rstmid_ctl got %b expected 00000", {rd_valid, rd_last, busy, access_request, xfer_error}); end
        checks++; if ({address, data_bytes} !== 40'h0) begin
            errors++; $display("FAIL rstmid_fields got %h/%h expected 0/0", address, data_bytes); end
        @(negedge clk);
        reset_n = 1'b1;
        write_enable = 1'b1; access_complete = 1'b1;
        repeat (3) tick();
        write_enable = 1'b0; access_complete = 1'b0;
        checks++; if ({rd_valid, busy, req_ready} !== 3'b001) begin
            errors++; $display("FAIL rstmid_ignore got %b expected 001", {rd_valid, busy, req_ready}); end
        test_len_mismatch(5, 6);
    endtask

    task automatic test_random();
        int len, n;
        for (int it = 0; it < 20; it++) begin
            len = $urandom_range(0, 15);
            n   = $urandom_range(0, 20);
            fill_tx(n);
            run_xfer($urandom, 8'(len), n, 1);
            drain();
            model(len, n, 1);
            checks++; if (err_pulses !== int'(exp_err)) begin
                errors++; $display("FAIL rand%0d_err got %0d expected %0d", it, err_pulses, exp_err); end
            checks++; if (got.size() !== exp_q.size()) begin
                errors++; $display("FAIL rand%0d_count got %0d expected %0d", it, got.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
                checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_byte%0d got %h expected %h", it, i, got[i], exp_q[i]); end
            end
        end
    endtask

`ifdef SPI_FAST_READ_EN
    task automatic test_fast();
        fill_tx(2);
        req_fast = 1'b1;
        run_xfer(32'h00ABCDEF, 8'd1, 2, 0);
        drain();
        checks++; if ({cap_cmd, cap_dv, cap_dc} !== {8'h0B, 1'b1, 3'd7}) begin
            errors++; $display("FAIL fast_on got %h/%b/%0d expected 0B/1/7", cap_cmd, cap_dv, cap_dc); end
        req_fast = 1'b0;
        run_xfer(32'h00ABCDEF, 8'd1, 2, 0);
        drain();
        checks++; if ({cap_cmd, cap_dv, cap_dc} !== {8'h03, 1'b0, 3'd0}) begin
            errors++; $display("FAIL fast_off got %h/%b/%0d expected 03/0/0", cap_cmd, cap_dv, cap_dc); end
    endtask
`endif

    initial begin
        req_valid = 1'b0; req_addr = '0; req_len = '0;
        access_complete = 1'b0; write_enable = 1'b0; write_data = '0; rd_ready = 1'b0;
`ifdef SPI_FAST_READ_EN
        req_fast = 1'b0;
`endif
        test_reset();
        test_single();
        test_backpressure();
        test_len_mismatch(7, 5);
        test_len_mismatch(1, 3);
        test_reset_mid();
        test_random();
`ifdef SPI_FAST_READ_EN
        test_fast();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_flash_read_sequencer.md
Name: spi_flash_read_sequencer

Overview:
- Upstream and downstream companion of the SPI master controller.
- Accepts host read requests (address, length) on a valid/ready port. Drives the controller's access-request field bundle, then waits for access_complete.
- Captures the received bytes the controller emits on write_enable/write_data into a FIFO.
- Streams the captured bytes to the host on a valid/ready port, with a last marker.

Parameters:
- FIFO_DEPTH, 16, byte FIFO entries; power of two, minimum 4.
- ADDR_BYTES, 3, flash address width in bytes (1..4); drives address_bytes = ADDR_BYTES-1.
- READ_CMD, 8'h03, opcode for normal read.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  host read request valid
- req_ready  out  1  sequencer can accept a request
- req_addr  in  32  flash byte address
- req_len  in  8  transfer length minus one (0 = 1 byte, 255 = 256 bytes)
- access_request  out  1  one-cycle start pulse to controller
- read_write_n  out  1  constant 1 (read)
- command  out  8  opcode
- address  out  32  latched req_addr
- address_bytes  out  2  ADDR_BYTES-1
- address_valid  out  1  constant 1
- dummy_cycles  out  3  dummy count
- dummy_valid  out  1  dummy phase enable
- data_bytes  out  8  latched req_len
- data_valid  out  1  constant 1
- access_complete  in  1  controller transaction-done pulse
- write_enable  in  1  controller received-byte strobe
- write_data  in  8  controller received byte
- rd_valid  out  1  output byte valid
- rd_ready  in  1  host accepts byte
- rd_data  out  8  output byte
- rd_last  out  1  final byte of request
- busy  out  1  state != IDLE
- xfer_error  out  1  one-cycle pulse on completion if error

Behaviour:
- Reset (async assert, sync-released by the environment):
  - state=IDLE, FIFO empty, counters 0.
  - access_request=0, rd_valid=0, rd_last=0, xfer_error=0, busy=0.
  - command=READ_CMD, address=0, data_bytes=0, dummy_valid=0, dummy_cycles=0.
- States: IDLE, ISSUE, WAIT.
- req_ready = (state==IDLE) && FIFO empty. A request is accepted on req_valid && req_ready.
- IDLE -> ISSUE on acceptance:
  - Latch req_addr into address and req_len into data_bytes.
  - Clear the received-byte counter rx_cnt and the overflow flag.
- ISSUE:
  - access_request=1 for exactly one cycle, then -> WAIT.
  - command, address, data_bytes and dummy fields are stable from ISSUE until return to IDLE.
- WAIT:
  - Each write_enable=1 cycle with rx_cnt <= data_bytes pushes {last, write_data} into the FIFO and increments rx_cnt. last = (rx_cnt == data_bytes).
  - Strobes with rx_cnt > data_bytes are discarded; FIFO is unchanged.
- WAIT -> IDLE on access_complete=1. xfer_error pulses in that same cycle if rx_cnt (including any push in that cycle) != data_bytes+1, or if overflow is set.
- access_complete is ignored in IDLE and ISSUE.
- FIFO rules:
  - Push when full drops the byte and sets sticky overflow; the exception is a pop in the same cycle, which frees the slot and lets the push succeed.
  - Simultaneous push and pop when not full: count unchanged.
  - No bypass: a byte pushed at edge N is visible on rd_valid/rd_data after edge N.
  - rd_data/rd_last are held stable while rd_valid && !rd_ready.
  - Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1 so full and empty are distinct.
- Reset asserted mid-transfer:
  - Immediate return to IDLE, FIFO flushed.
  - Any later controller strobes are ignored until a new request is accepted.

Optional Feature:
- Macro: SPI_FAST_READ_EN.
- Defined:
  - Extra input req_fast (1 bit), latched on acceptance.
  - req_fast=1 gives command=8'h0B, dummy_valid=1, dummy_cycles=3'd7 (8 dummy clocks).
  - req_fast=0 behaves as the normal read below.
- Not defined:
  - No req_fast port.
  - command=READ_CMD, dummy_valid=0, dummy_cycles=0 always.

Test Plan:
- Single 4-byte read: req_addr=32'h00012345, req_len=3; controller model returns A0,A1,A2,A3 then access_complete -> access_request pulses once with address=32'h00012345, data_bytes=3, address_bytes=2; rd stream is A0..A3 with rd_last only on A3; xfer_error=0; req_ready returns after the FIFO drains.
- Backpressure/full: FIFO_DEPTH=16, req_len=19, rd_ready=0 until complete -> first 16 bytes stored; overflow set; xfer_error pulses; 16 bytes stream with rd_last=0 throughout.
- Short transfer: req_len=7, model sends 5 bytes then access_complete -> xfer_error=1 for one cycle; 5 bytes delivered; no rd_last.
- Excess strobes: req_len=1, model sends 3 bytes -> only the first 2 are delivered, the second with rd_last=1; xfer_error=0.
- Reset mid-WAIT: assert reset_n=0 after 2 of 8 bytes -> outputs go to reset values asynchronously; rd_valid=0; the next request proceeds normally.
- SPI_FAST_READ_EN defined, req_fast=1 -> command=8'h0B, dummy_valid=1, dummy_cycles=7; with req_fast=0 -> command=8'h03, dummy_valid=0.
